// File: rtl/conv3x3_window_mac.sv
// conv3x3_window_mac: 3-stage 3x3 multiply-accumulate with bias, ReLU/shift/clamp output and global stall.
module conv3x3_window_mac #(
    parameter int STREAM_DATA_WIDTH = 72,
    parameter int ACC_WIDTH         = 24,
    parameter int BIAS_WIDTH        = 16,
    parameter int OUT_SHIFT         = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [STREAM_DATA_WIDTH-1:0] window_data,
    input  logic                         window_valid,
    output logic                         window_rdy,
    input  logic [STREAM_DATA_WIDTH-1:0] weight_data,
    input  logic [BIAS_WIDTH-1:0]        bias_data,
    input  logic                         weight_load,
    output logic [ACC_WIDTH-1:0]         conv_sum,
    output logic [7:0]                   conv_pixel,
    output logic                         conv_valid,
    input  logic                         conv_rdy,
    output logic                         busy
);
    logic [STREAM_DATA_WIDTH-1:0]  weights;
    logic signed [BIAS_WIDTH-1:0]  bias, b1, b2;
    logic signed [16:0]            prod_c [9];
    logic signed [16:0]            p1 [9];
    logic signed [ACC_WIDTH-1:0]   ps_c [3];
    logic signed [ACC_WIDTH-1:0]   ps [3];
    logic signed [ACC_WIDTH-1:0]   sum_c, shifted;
    logic [7:0]                    pix_c;
    logic                          v1, v2, v3, advance, accept;

    assign advance    = !v3 || conv_rdy;
    assign window_rdy = advance && !reset;
    assign accept     = window_valid && window_rdy;
    assign conv_valid = v3;
    assign busy       = v1 || v2 || v3;

    // pixels are unsigned, so widen with a zero before the signed multiply
    for (genvar k = 0; k < 9; k++) begin : g_prod
        assign prod_c[k] = 17'($signed({1'b0, window_data[8*k +: 8]})) * 17'($signed(weights[8*k +: 8]));
    end

    for (genvar j = 0; j < 3; j++) begin : g_psum
        assign ps_c[j] = ACC_WIDTH'(p1[3*j]) + ACC_WIDTH'(p1[3*j+1]) + ACC_WIDTH'(p1[3*j+2]);
    end

    assign sum_c   = ps[0] + ps[1] + ps[2] + ACC_WIDTH'(b2);
    assign shifted = sum_c >>> OUT_SHIFT;
    // shifted is non-negative whenever the sum is positive, so any high bit means overflow
    assign pix_c   = (sum_c[ACC_WIDTH-1] || sum_c == '0) ? 8'd0 :
                     (|shifted[ACC_WIDTH-1:8]) ? 8'd255 : shifted[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            weights    <= '0;
            bias       <= '0;
            p1         <= '{default: '0};
            b1         <= '0;
            ps         <= '{default: '0};
            b2         <= '0;
            conv_sum   <= '0;
            conv_pixel <= '0;
            v1         <= 1'b0;
            v2         <= 1'b0;
            v3         <= 1'b0;
        end else begin
            if (weight_load) begin
                weights <= weight_data;
                bias    <= bias_data;
            end
            if (advance) begin
                v1 <= accept;
                if (accept) begin
                    p1 <= prod_c;
                    b1 <= bias;
                end
                v2         <= v1;
                ps         <= ps_c;
                b2         <= b1;
                v3         <= v2;
                conv_sum   <= sum_c;
                conv_pixel <= pix_c;
            end
        end
    end
endmodule

// File: tb/tb_conv3x3_window_mac.sv
// tb_conv3x3_window_mac: directed vector table plus multi-cycle stall, weight-swap and reset sequences.
module tb_conv3x3_window_mac;
    logic               clk = 0;
    logic               reset = 1;
    logic [71:0]        window_data = '0;
    logic               window_valid = 0;
    logic               window_rdy;
    logic [71:0]        weight_data = '0;
    logic [15:0]        bias_data = '0;
    logic               weight_load = 0;
    logic signed [23:0] conv_sum;
    logic [7:0]         conv_pixel;
    logic               conv_valid;
    logic               conv_rdy = 1;
    logic               busy;

    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        logic [71:0]        w;
        logic [15:0]        b;
        logic [71:0]        win;
        logic signed [23:0] s;
        logic [7:0]         p;
    } vec_t;

    vec_t vecs[12];

    always #5 clk = ~clk;

    conv3x3_window_mac dut (
        .clk(clk), .reset(reset),
        .window_data(window_data), .window_valid(window_valid), .window_rdy(window_rdy),
        .weight_data(weight_data), .bias_data(bias_data), .weight_load(weight_load),
        .conv_sum(conv_sum), .conv_pixel(conv_pixel), .conv_valid(conv_valid),
        .conv_rdy(conv_rdy), .busy(busy)
    );

    task automatic check(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [71:0] rep(input logic [7:0] b);
        return {9{b}};
    endfunction

    task automatic load(input logic [71:0] w, input logic [15:0] b);
        @(negedge clk);
        weight_data = w;
        bias_data   = b;
        weight_load = 1;
        @(negedge clk);
        weight_load = 0;
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int lat;
        load(v.w, v.b);
        window_data  = v.win;
        window_valid = 1;
        @(posedge clk);
        #1 window_valid = 0;
        lat = 0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (conv_valid) begin
                lat = c;
                break;
            end
        end
        check($sformatf("v%0d_latency", idx), lat, 3);
        check($sformatf("v%0d_sum", idx), conv_sum, v.s);
        check($sformatf("v%0d_pixel", idx), conv_pixel, v.p);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int sent, got, extra;
        bit stall_seen;
        logic signed [23:0] res[8];

        vecs[0]  = '{rep(8'h01), 16'd0,     rep(8'd10), 24'sd90,     8'd5};
        vecs[1]  = '{72'h0000000100000000, 16'd0, 72'h38312A231C150E0700, 24'sd28, 8'd1};
        vecs[2]  = '{72'h1, 16'd0, 72'h38312A231C150E0700, 24'sd0, 8'd0};
        vecs[3]  = '{72'h010000000000000000, 16'd0, 72'h38312A231C150E0700, 24'sd56, 8'd3};
        vecs[4]  = '{rep(8'hFF), 16'd0,     rep(8'hFF), -24'sd2295,  8'd0};
        vecs[5]  = '{rep(8'hFF), 16'd2295,  rep(8'hFF), 24'sd0,      8'd0};
        vecs[6]  = '{rep(8'h7F), 16'h7FFF,  rep(8'hFF), 24'sd324232, 8'd255};
        vecs[7]  = '{rep(8'h01), 16'hFFA5,  rep(8'd10), -24'sd1,     8'd0};
        vecs[8]  = '{rep(8'h01), 16'd3916,  rep(8'd20), 24'sd4096,   8'd255};
        vecs[9]  = '{rep(8'h01), 16'd3900,  rep(8'd20), 24'sd4080,   8'd255};
        vecs[10] = '{rep(8'h01), 16'd3899,  rep(8'd20), 24'sd4079,   8'd254};
        vecs[11] = '{72'h1,      16'd0,     72'h0F,     24'sd15,     8'd0};

        repeat (3) @(negedge clk);
        check("rst_window_rdy", window_rdy, 0);
        check("rst_conv_valid", conv_valid, 0);
        check("rst_busy", busy, 0);
        reset = 0;
        @(negedge clk);
        check("post_rst_window_rdy", window_rdy, 1);
        check("post_rst_conv_sum", conv_sum, 0);
        check("post_rst_conv_pixel", conv_pixel, 0);

        for (int i = 0; i < 12; i++) run_vec(vecs[i], i);

        // back-to-back stream with downstream stalled for cycles 2..8
        load(rep(8'h01), 16'd0);
        sent = 0;
        got = 0;
        stall_seen = 0;
        for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
            conv_rdy     = !(cyc >= 2 && cyc <= 8);
            window_valid = sent < 6;
            window_data  = rep(8'(sent + 1));
            #1;
            if (window_valid && !window_rdy) stall_seen = 1;
            if (cyc == 8) check("stall_hold_sum", conv_sum, 9);
            if (window_valid && window_rdy) sent++;
            if (conv_valid && conv_rdy) begin
                if (got < 8) res[got] = conv_sum;
                got++;
            end
            @(negedge clk);
        end
        window_valid = 0;
        conv_rdy = 1;
        extra = 0;
        repeat (5) begin
            #1;
            if (conv_valid) extra++;
            @(negedge clk);
        end
        check("stream_sent", sent, 6);
        check("stream_got", got, 6);
        check("stream_extra", extra, 0);
        check("stream_stall_seen", stall_seen, 1);
        for (int i = 0; i < 6; i++) check($sformatf("stream_res%0d", i), res[i], 9 * (i + 1));

        // weights and bias change on the same edge window A is accepted
        load(rep(8'h01), 16'd0);
        weight_data  = rep(8'h02);
        bias_data    = 16'd100;
        weight_load  = 1;
        window_data  = rep(8'd10);
        window_valid = 1;
        @(negedge clk);
        weight_load = 0;
        @(negedge clk);
        window_valid = 0;
        got = 0;
        for (int c = 0; c < 10 && got < 2; c++) begin
            if (conv_valid) begin
                res[got] = conv_sum;
                got++;
            end
            @(negedge clk);
        end
        check("swap_got", got, 2);
        check("swap_old_weights", res[0], 90);
        check("swap_new_weights", res[1], 280);

        // reset with all three stages occupied
        window_data  = rep(8'd3);
        window_valid = 1;
        repeat (3) @(negedge clk);
        window_valid = 0;
        conv_rdy = 0;
        #1;
        check("full_busy", busy, 1);
        check("full_conv_valid", conv_valid, 1);
        reset = 1;
        @(negedge clk);
        check("midrst_conv_valid", conv_valid, 0);
        check("midrst_busy", busy, 0);
        check("midrst_window_rdy", window_rdy, 0);
        reset = 0;
        conv_rdy = 1;
        extra = 0;
        repeat (6) begin
            @(negedge clk);
            if (conv_valid) extra++;
        end
        check("midrst_no_output", extra, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
